pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_rs, id_rt  in  5  ID-stage source registers
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- ex_rs, ex_rt  in  5  EX-stage source registers
- ex_rd  in  5  EX destination register
- ex_regwrite  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX branch or jump resolved taken
- mem_rd  in  5  EX/MEM destination register
- mem_regwrite  in  1  EX/MEM instruction writes a register
- mem_req  in  1  MEM stage accesses data memory
- mem_ready  in  1  data memory completes this cycle
- wb_rd  in  5  MEM/WB destination register
- wb_regwrite  in  1  MEM/WB instruction writes a register
- pc_en, ifid_en, idex_en, exmem_en  out  1  stage-register load enables
- ifid_flush, idex_flush, memwb_flush  out  1  load a bubble (all control fields 0)
- fwd_a, fwd_b  out  2  EX operand source: 00 register file, 10 EX/MEM ALU_out, 01 MEM/WB
- stall_cycles  out  16  saturating count of cycles with pc_en=0
- mem_timeout  out  1  sticky memory-timeout flag

Function
REQ-003 Register $0 SHALL never match a hazard or forwarding condition.
REQ-004 The enable, flush and fwd outputs SHALL be combinational from the inputs and state; stall_cycles and mem_timeout SHALL be registered.
REQ-005 The memory-wait condition SHALL be mem_req=1 and mem_ready=0; while it holds: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, all other flushes 0.
REQ-006 The load-use condition SHALL be ex_memread=1, ex_regwrite=1, ex_rd!=0, and ex_rd equal to id_rs with id_uses_rs=1 or to id_rt with id_uses_rt=1; it SHALL drive pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle per occurrence.
REQ-007 The branch condition SHALL be ex_branch_taken=1; it SHALL drive ifid_flush=1 and idex_flush=1, with pc_en=1.
REQ-008 Priority SHALL be memory-wait, then branch, then load-use; a lower-priority event is evaluated again each cycle while its inputs persist.
REQ-009 With no condition active, all enables SHALL be 1 and all flushes 0.
REQ-010 The state machine SHALL have states RUN and MEM_WAIT: RUN to MEM_WAIT on memory-wait; MEM_WAIT to RUN on the cycle mem_ready=1, which releases the freeze that same cycle.
REQ-011 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle; at the value 255 mem_timeout SHALL set and remain set until reset, and the FSM SHALL keep waiting.
REQ-012 stall_cycles SHALL increment on each cycle with pc_en=0 and saturate at 16'hFFFF.

Reset
REQ-013 While rst=1: state RUN, wait counter 0, stall_cycles 0, mem_timeout 0; the combinational outputs SHALL follow their inputs.
REQ-014 Asserting rst during MEM_WAIT SHALL return the FSM to RUN on the next edge.

Configuration
REQ-015 Macro PIPE_CTRL_FWD_EN SHALL select forwarding.
REQ-016 With the macro defined, fwd_a SHALL be 10 if mem_regwrite=1 and mem_rd=ex_rs!=0; otherwise 01 if wb_regwrite=1 and wb_rd=ex_rs!=0; otherwise 00. fwd_b SHALL follow the same rule using ex_rt.
REQ-017 Without the macro, fwd_a and fwd_b SHALL be 00, and the load-use condition SHALL widen to any used ID source matching ex_rd (with ex_regwrite=1) or mem_rd (with mem_regwrite=1), irrespective of ex_memread.

Verification
REQ-018 Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0->1.
REQ-019 Branch plus load-use in the same cycle: ex_branch_taken=1 -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-020 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> all enables 0 and memwb_flush=1 for 3 cycles, then RUN; stall_cycles=3.
REQ-021 Timeout: mem_ready held 0 for 256 cycles -> mem_timeout=1; rst=1 -> mem_timeout=0, state RUN.
REQ-022 Forwarding (PIPE_CTRL_FWD_EN): mem_rd=wb_rd=ex_rs=7, both regwrites 1 -> fwd_a=10; ex_rs=0 -> fwd_a=00.
REQ-023 No forwarding (macro absent): mem_regwrite=1, mem_rd=3, id_rt=3, id_uses_rt=1 -> pc_en=0, idex_flush=1, fwd_b=00.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall controller pipe_ctrl.
// The master side drives stage register fields; the slave (controller) returns enables, flushes and forwarding selects.
interface pipe_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_branch_taken;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic        mem_req;
    logic        mem_ready;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        memwb_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cycles;
    logic        mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd,
               ex_regwrite, ex_memread, ex_branch_taken, mem_rd, mem_regwrite,
               mem_req, mem_ready, wb_rd, wb_regwrite,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_flush, fwd_a, fwd_b, stall_cycles, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd,
               ex_regwrite, ex_memread, ex_branch_taken, mem_rd, mem_regwrite,
               mem_req, mem_ready, wb_rd, wb_regwrite,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_flush, fwd_a, fwd_b, stall_cycles, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze, branch flush, load-use stall, operand forwarding.
// Define PIPE_CTRL_FWD_EN to enable forwarding; without it, any in-flight writer of a used ID source stalls.
module pipe_ctrl (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        timeout_q, timeout_d;
    logic        mem_wait, branch, load_use;

    function automatic logic id_hit(input logic [4:0] rd, input logic rw,
                                    input logic [4:0] rs, input logic use_rs,
                                    input logic [4:0] rt, input logic use_rt);
        return rw && (rd != 5'd0) && ((use_rs && rs == rd) || (use_rt && rt == rd));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_rd, input logic m_rw,
                                           input logic [4:0] w_rd, input logic w_rw);
        if (src == 5'd0)
            return 2'b00;
        else if (m_rw && m_rd == src)
            return 2'b10;
        else if (w_rw && w_rd == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign mem_wait = bus.mem_req && !bus.mem_ready;
    assign branch   = bus.ex_branch_taken;

`ifdef PIPE_CTRL_FWD_EN
    assign load_use = bus.ex_memread &&
                      id_hit(bus.ex_rd, bus.ex_regwrite, bus.id_rs, bus.id_uses_rs,
                             bus.id_rt, bus.id_uses_rt);
    assign bus.fwd_a = fwd_sel(bus.ex_rs, bus.mem_rd, bus.mem_regwrite, bus.wb_rd, bus.wb_regwrite);
    assign bus.fwd_b = fwd_sel(bus.ex_rt, bus.mem_rd, bus.mem_regwrite, bus.wb_rd, bus.wb_regwrite);
`else
    // Nothing is bypassed, so an ALU result still in EX or MEM must also hold the consumer in ID.
    assign load_use = id_hit(bus.ex_rd, bus.ex_regwrite, bus.id_rs, bus.id_uses_rs,
                             bus.id_rt, bus.id_uses_rt) ||
                      id_hit(bus.mem_rd, bus.mem_regwrite, bus.id_rs, bus.id_uses_rs,
                             bus.id_rt, bus.id_uses_rt);
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        timeout_d       = timeout_q;
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.idex_en     = 1'b1;
        bus.exmem_en    = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.memwb_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = RUN;
                end else begin
                    if (wait_cnt_q != 8'hFF)
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == 8'hFF)
                        timeout_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (mem_wait) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.exmem_en    = 1'b0;
            bus.memwb_flush = 1'b1;
        end else if (branch) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else if (load_use) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
        end

        stall_d = stall_q;
        if (!bus.pc_en && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            stall_q    <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.mem_timeout  = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table through a scoreboard queue, then memory-wait and timeout sequences.
// Builds with or without PIPE_CTRL_FWD_EN; expectations switch accordingly.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();
    pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
    localparam logic [6:0] C_NORM = 7'b1111_000;
    localparam logic [6:0] C_LU   = 7'b0011_010;
    localparam logic [6:0] C_BR   = 7'b1111_110;
    localparam logic [6:0] C_MW   = 7'b0000_001;
    localparam logic [6:0] C_WIDE = FWD ? C_NORM : C_LU;
    localparam logic [1:0] F10    = FWD ? 2'b10 : 2'b00;
    localparam logic [1:0] F01    = FWD ? 2'b01 : 2'b00;

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       ur, ut;
        logic [4:0] ex_rs, ex_rt, ex_rd;
        logic       ex_rw, ex_mr, br;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [6:0] ctrl;
        logic [1:0] fa, fb;
        string      name;
    } vec_t;

    typedef struct {
        logic [6:0] ctrl;
        logic [1:0] fa, fb;
        string      name;
    } exp_t;

    vec_t vecs[14];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_model = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                bus.ifid_flush, bus.idex_flush, bus.memwb_flush};
    endfunction

    task automatic drive_idle();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
        bus.ex_rs = 5'd0; bus.ex_rt = 5'd0; bus.ex_rd = 5'd0;
        bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.mem_rd = 5'd0; bus.mem_regwrite = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
        bus.wb_rd = 5'd0; bus.wb_regwrite = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.id_rs = v.id_rs; bus.id_rt = v.id_rt; bus.id_uses_rs = v.ur; bus.id_uses_rt = v.ut;
        bus.ex_rs = v.ex_rs; bus.ex_rt = v.ex_rt; bus.ex_rd = v.ex_rd;
        bus.ex_regwrite = v.ex_rw; bus.ex_memread = v.ex_mr; bus.ex_branch_taken = v.br;
        bus.mem_rd = v.mem_rd; bus.mem_regwrite = v.mem_rw;
        bus.wb_rd = v.wb_rd; bus.wb_regwrite = v.wb_rw;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic push_exp(input logic [6:0] c, input logic [1:0] fa, input logic [1:0] fb,
                            input string name);
        exp_t e;
        e.ctrl = c; e.fa = fa; e.fb = fb; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.name, "_ctrl"}, 32'(ctrl_now()), 32'(e.ctrl));
            chk({e.name, "_fwd_a"}, 32'(bus.fwd_a), 32'(e.fa));
            chk({e.name, "_fwd_b"}, 32'(bus.fwd_b), 32'(e.fb));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_NORM, 2'b00, 2'b00, "idle"};
        vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_LU, 2'b00, 2'b00, "lu_rs"};
        vecs[2]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_NORM, 2'b00, 2'b00, "lu_unused"};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_NORM, 2'b00, 2'b00, "lu_r0"};
        vecs[4]  = '{5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_LU, 2'b00, 2'b00, "lu_rt"};
        vecs[5]  = '{5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_WIDE, 2'b00, 2'b00, "alu_dep_ex"};
        vecs[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, C_BR, 2'b00, 2'b00, "br_over_lu"};
        vecs[7]  = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, C_WIDE, 2'b00, 2'b00, "mem_dep"};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, C_NORM, F10, 2'b00, "fwd_a_mem_prio"};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, C_NORM, 2'b00, 2'b00, "fwd_r0"};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, C_NORM, 2'b00, F01, "fwd_b_wb"};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0, 5'd6, 1'b1, C_NORM, F01, 2'b00, "fwd_a_wb"};
        vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, C_NORM, 2'b00, F10, "fwd_b_mem"};
        vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, C_BR, 2'b00, 2'b00, "branch"};

        // Reset: registered outputs clear, combinational outputs follow inputs.
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
        chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
        chk("rst_ctrl_idle", 32'(ctrl_now()), 32'(C_NORM));
        bus.ex_branch_taken = 1'b1;
        #1 chk("rst_ctrl_branch", 32'(ctrl_now()), 32'(C_BR));
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();

        // Vector table; each vector occupies exactly one clock edge.
        for (int i = 0; i < 14; i++) begin
            drive_vec(vecs[i]);
            push_exp(vecs[i].ctrl, vecs[i].fa, vecs[i].fb, vecs[i].name);
            if (vecs[i].ctrl[6] == 1'b0) stall_model++;
            pop_compare();
            @(posedge clk); #1;
        end
        drive_idle();
        @(negedge clk);
        chk("table_stall_cycles", 32'(bus.stall_cycles), 32'(stall_model));

        // Memory wait for 3 cycles (branch raised mid-wait must not win), then ready releases.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
            bus.ex_branch_taken = (c == 1);
            push_exp(C_MW, 2'b00, 2'b00, $sformatf("memwait_%0d", c));
            pop_compare();
            @(posedge clk); #1;
        end
        bus.ex_branch_taken = 1'b0;
        bus.mem_ready = 1'b1;
        push_exp(C_NORM, 2'b00, 2'b00, "mem_ready_release");
        pop_compare();
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("memwait_stall_cycles", 32'(bus.stall_cycles), 32'd3);

        // Timeout: flag sets on the 256th waiting edge and stays while the FSM keeps waiting.
        do_reset();
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        repeat (255) @(posedge clk);
        #1 chk("timeout_before", 32'(bus.mem_timeout), 32'd0);
        @(posedge clk);
        #1 chk("timeout_set", 32'(bus.mem_timeout), 32'd1);
        chk("timeout_still_frozen", 32'(bus.pc_en), 32'd0);
        repeat (5) @(posedge clk);
        #1 chk("timeout_sticky", 32'(bus.mem_timeout), 32'd1);
        chk("timeout_stall_cycles", 32'(bus.stall_cycles), 32'd261);

        // Reset during MEM_WAIT: clears flags; wait count must restart from RUN entry.
        rst = 1'b1;
        @(posedge clk);
        #1 chk("rst_in_wait_timeout", 32'(bus.mem_timeout), 32'd0);
        chk("rst_in_wait_stall", 32'(bus.stall_cycles), 32'd0);
        rst = 1'b0;
        repeat (255) @(posedge clk);
        #1 chk("rewait_before", 32'(bus.mem_timeout), 32'd0);
        @(posedge clk);
        #1 chk("rewait_set", 32'(bus.mem_timeout), 32'd1);

        drive_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
